// File: rtl/mplier_pkg.sv
// Shared constants and the round-robin pick helper for multiplier-sharing blocks.
package mplier_pkg;

  localparam int unsigned OPER_W  = 8;
  localparam int unsigned PROD_W  = 16;
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned PTR_W   = 3;

  // One-hot grant of the first valid requester at or after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int unsigned        pos;
    logic [PTR_W-1:0]   idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      pos = (32'(ptr) + k) % n;
      idx = pos[PTR_W-1:0];
      if (k < n && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/mplier8x8.sv
// Combinational signed 8x8 multiplier; raw 16-bit two's complement product.
module mplier8x8 (
  output logic signed [15:0] product,
  input  logic signed [7:0]  a,
  input  logic signed [7:0]  b
);

  assign product = a * b;

endmodule

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: combinational pick plus a registered rotating pointer.
module rr_arbiter_n
  import mplier_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W-1:0]    ptr_q;
  logic [MAX_REQ-1:0] valid_ext;
  logic [MAX_REQ-1:0] pick;

  // Widen the request vector to the helper's fixed width.
  always_comb begin
    valid_ext              = '0;
    valid_ext[NUM_REQ-1:0] = valid;
  end

  assign pick  = rr_pick(valid_ext, PTR_W'(ptr_q), NUM_REQ);
  assign grant = en ? pick[NUM_REQ-1:0] : '0;

  if (NUM_REQ < MAX_REQ) begin : g_pad
    logic unused_pick;
    assign unused_pick = ^pick[MAX_REQ-1:NUM_REQ];
  end

  // Encode the one-hot grant into an index.
  always_comb begin
    grant_id = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_id = ID_W'(i);
    end
  end

  // Move the pointer just past the winner so it has lowest priority next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (|grant) begin
      ptr_q <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/mplier_share_arb.sv
// Shares one combinational 8x8 multiplier among NUM_REQ requesters through a
// round-robin front end and a two-stage (operand, product) pipeline.
module mplier_share_arb
  import mplier_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*OPER_W-1:0] req_a,
  input  logic [NUM_REQ*OPER_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic signed [PROD_W-1:0]  rsp_product
);

  logic                     s1_valid_q;
  logic signed [OPER_W-1:0] s1_a_q;
  logic signed [OPER_W-1:0] s1_b_q;
  logic [ID_W-1:0]          s1_id_q;
  logic                     rsp_valid_q;
  logic [ID_W-1:0]          rsp_id_q;
  logic signed [PROD_W-1:0] rsp_product_q;

  logic                     adv1;
  logic                     adv2;
  logic                     xfer;
  logic [NUM_REQ-1:0]       grant;
  logic [ID_W-1:0]          grant_id;
  logic [OPER_W-1:0]        gnt_a;
  logic [OPER_W-1:0]        gnt_b;
  logic signed [PROD_W-1:0] product;

  // A stage may advance when it is empty or its successor is advancing.
  assign adv2 = !rsp_valid_q || rsp_ready;
  assign adv1 = !s1_valid_q || adv2;

  rr_arbiter_n #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .en       (adv1 && !rst),
    .valid    (req_valid),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  // Select the granted requester's operands.
  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_a = req_a[i*OPER_W +: OPER_W];
        gnt_b = req_b[i*OPER_W +: OPER_W];
      end
    end
  end

  // Stage 1: operand register in front of the multiplier array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
    end else if (adv1) begin
      s1_valid_q <= xfer;
      if (xfer) begin
        s1_a_q  <= gnt_a;
        s1_b_q  <= gnt_b;
        s1_id_q <= grant_id;
      end
    end
  end

  mplier8x8 u_mul (
    .product (product),
    .a       (s1_a_q),
    .b       (s1_b_q)
  );

  // Stage 2: product register driving the tagged response channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
    end else if (adv2) begin
      rsp_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        rsp_id_q      <= s1_id_q;
        rsp_product_q <= product;
      end
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;

endmodule

// File: tb/tb_mplier_share_arb.sv
// Bench for mplier_share_arb: a slot-level behavioural model checked every cycle,
// plus directed tests pinned with hand-computed literals.
module tb_mplier_share_arb;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_a;
  logic [N*8-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [15:0]    rsp_product;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the response slot, the operand slot (holding the finished product),
  // and the round-robin pointer.
  bit          m_rv, m_sv;
  int          m_rid, m_sid, m_ptr;
  logic [15:0] m_rp, m_sp;
  logic [N-1:0] last_ready;

  int exp_seq4[5] = '{0, 1, 2, 3, 0};
  int exp_bp[6]   = '{0, 1, 2, 3, 0, 1};
  int got_g[7];
  int got_r[7];
  int got_acc[6];

  mplier_share_arb #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50)
        $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at %0t",
                 name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [15:0] prod(input logic signed [7:0] a, input logic signed [7:0] b);
    int p;
    p = int'(a) * int'(b);
    return p[15:0];
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_rv = 0; m_sv = 0; m_rid = 0; m_sid = 0; m_ptr = 0; m_rp = '0; m_sp = '0;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  // One clock cycle: called at a falling edge with inputs already driven.
  task automatic step();
    logic [N-1:0] eg;
    int gi, idx;
    bit rsp_free, s1_free;
    #1;
    rsp_free = !m_rv || rsp_ready;
    s1_free  = !m_sv || rsp_free;
    gi = -1;
    eg = '0;
    if (!rst && s1_free) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (gi < 0 && req_valid[idx]) gi = idx;
      end
    end
    if (gi >= 0) eg[gi] = 1'b1;
    last_ready = req_ready;
    chk("req_ready", 32'(req_ready), 32'(eg));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    chk("rsp_id", 32'(rsp_id), m_rid);
    chk("rsp_product", 32'(rsp_product), 32'(m_rp));
    if (rst) begin
      model_reset();
    end else begin
      if (rsp_free) begin
        m_rv = m_sv;
        if (m_sv) begin
          m_rid = m_sid;
          m_rp  = m_sp;
        end
      end
      if (s1_free) begin
        m_sv = (gi >= 0);
        if (gi >= 0) begin
          m_sid = gi;
          m_sp  = prod(req_a[gi*8 +: 8], req_b[gi*8 +: 8]);
          m_ptr = (gi + 1) % N;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int waited;
    bit got;
    rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    last_ready = '0;
    #1;
    model_reset();
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_id", 32'(rsp_id), 0);
    chk("reset_rsp_product", 32'(rsp_product), 0);
    chk("reset_req_ready", 32'(req_ready), 0);
    req_valid = '0;
    do_reset();

    // Single request from requester 2: -128 * -128.
    req_valid = 4'b0100; set_op(2, 8'h80, 8'h80);
    #1 chk("single_grant", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    step();
    #1;
    chk("single_lat_valid", 32'(rsp_valid), 1);
    chk("single_id", 32'(rsp_id), 2);
    chk("single_prod", 32'(rsp_product), 32'd16384);
    step(); step();

    // 127 * -128 via requester 0, then 0 * -77 via requester 1.
    req_valid = 4'b0001; set_op(0, 8'h7f, 8'h80);
    step();
    req_valid = '0;
    step();
    #1 chk("prod_127x-128", 32'(rsp_product), 32'h0000c080);
    step();
    req_valid = 4'b0010; set_op(1, 8'h00, 8'hb3);
    step();
    req_valid = '0;
    step();
    #1;
    chk("prod_0xneg", 32'(rsp_product), 0);
    chk("prod_0x_id", 32'(rsp_id), 1);
    step(); step();

    // All four valid after reset: grants rotate 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 8'(i + 1), 8'(3 * i - 5));
    req_valid = '1;
    for (int i = 0; i < 7; i++) begin
      #1;
      got_g[i] = oh_idx(req_ready);
      got_r[i] = rsp_valid ? int'(rsp_id) : -1;
      step();
    end
    for (int i = 0; i < 5; i++) begin
      chk("rot_grant", got_g[i], exp_seq4[i]);
      chk("rot_rsp_id", got_r[i+2], exp_seq4[i]);
    end
    req_valid = '0;
    step(); step(); step();

    // Backpressure: two in flight then stall; release drains in grant order.
    do_reset();
    rsp_ready = 1'b0;
    req_valid = '1;
    step(); step();
    #1 chk("bp_ready_zero", 32'(req_ready), 0);
    step(); step(); step();
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 got_acc[i] = rsp_valid ? int'(rsp_id) : -1;
      step();
    end
    for (int i = 0; i < 6; i++) chk("bp_accept_id", got_acc[i], exp_bp[i]);

    // Async reset mid-cycle with both stages full.
    rsp_ready = 1'b0;
    step(); step();
    #2 rst = 1'b1;
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 0);
    chk("async_req_ready", 32'(req_ready), 0);
    model_reset();
    @(negedge clk);
    step();
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    step(); step(); step();
    #1 chk("no_stale_rsp", 32'(rsp_valid), 0);
    req_valid = '1;
    #1 chk("ptr_restart", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    step(); step(); step();

    // Hog: requester 0 always valid, requester 3 raises once and holds.
    do_reset();
    req_valid = 4'b0001;
    step(); step(); step();
    req_valid = 4'b1001;
    waited = 0;
    got = 0;
    while (!got && waited < 8) begin
      #1;
      if (req_ready[3]) got = 1;
      else begin
        step();
        waited++;
      end
    end
    chk("hog_granted_within_4", 32'(got && waited <= 3), 1);
    step();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step(); step(); step();

    // Random traffic with hold-until-accepted requesters and random backpressure.
    do_reset();
    last_ready = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !last_ready[i])) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          set_op(i, 8'($urandom), 8'($urandom));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0; rsp_ready = 1'b1;
    step(); step(); step();

    // Exhaustive operand sweep through requester 0.
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        set_op(0, 8'(a), 8'(b));
        step();
      end
    end
    req_valid = '0;
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
